vend_dp_gen: RTL and testbench
==============================

Name: vend_dp_gen

Overview:
- Parametrised next-generation vending-machine datapath. Holds N_ITEMS item stocks and a change bank, and accumulates credit from coin/bill pulses.
- On vend, checks funds and exact-change feasibility, dispenses items, then pays change one coin per cycle.
- Sits between the front-panel/coin-acceptor pulse logic and the dispenser/coin-hopper actuators, replacing the fixed 4-item datapath.
- All money is in quarter units: $0.25 = 1.

Parameters:
- N_ITEMS, 4, number of item slots.
- MONEY_W, 16, credit/price width in quarter units.
- CNT_W, 8, width of stock and coin-bank counters.
- PRICES, {16'd4,16'd5,16'd6,16'd7}, packed per-item prices; item i = PRICES[i*MONEY_W +: MONEY_W], so item0=7, item3=4.
- INIT_STOCK, 4, per-item stock after reset/restock.
- INIT_C1, 2; INIT_C05, 2; INIT_C025, 0: initial bank counts for $1, $0.50, $0.25.

Ports:
- in_clka  in  1  sole clock, rising edge.
- in_restart_n  in  1  synchronous active-low reset.
- in_sel  in  N_ITEMS  one-cycle pulses that toggle item selection.
- in_ins_5, in_ins_1, in_ins_05, in_ins_025  in  1 each  inserted-money pulses (20/4/2/1 units).
- in_vend  in  1  purchase request pulse.
- in_cancel  in  1  refund request pulse.
- in_restock  in  1  reload item stock pulse.
- out_stock  out  N_ITEMS  1 = stock > 0.
- out_csel  out  N_ITEMS  confirmed selections.
- out_credit  out  MONEY_W  current credit.
- out_total  out  MONEY_W  sum of selected prices.
- out_spit  out  N_ITEMS  one-cycle item dispense pulse.
- out_coin_1, out_coin_05, out_coin_025  out  1 each  one-cycle pulse per coin paid.
- out_busy  out  1  high in any state but IDLE.
- out_done  out  1  one-cycle transaction-complete pulse.
- out_err_funds, out_err_nochange, out_reject  out  1 each  one-cycle error pulses.

Behaviour:
- Reset (in_restart_n=0 at a rising edge):
  - state=IDLE; credit=0; csel=0; stock=INIT_STOCK; bank=INIT_C*.
  - All pulse outputs = 0.
  - Reset overrides everything, including mid-CHANGE; no further coin pulses follow.
- FSM states: IDLE, CHECK, VEND, CHANGE, DONE.
- IDLE accepts all inputs.
  - Coin pulses in the same cycle are summed into credit.
  - $1/$0.50/$0.25 also increment the bank, saturating at 2^CNT_W-1. $5 goes to credit only.
  - If the credit sum would exceed 2^MONEY_W-1, the whole cycle's insertion is ignored and out_reject pulses.
- in_sel[i] toggles csel[i]. If stock[i]==0, csel[i] is forced to 0.
- out_total is combinational from csel.
- in_restock sets all stock to INIT_STOCK. Bank is unchanged.
- IDLE input priority: cancel > vend > sel/insert/restock.
  - Cancel or vend in a cycle ignores sel/restock that cycle.
  - Coins in that cycle are still credited.
- in_vend → CHECK:
  - total==0 or credit<total: out_err_funds pulse, back to IDLE, nothing changed.
  - Otherwise change = credit-total, evaluated by the planner.
  - Infeasible: out_err_nochange pulse, back to IDLE, credit and csel retained.
  - Feasible: VEND.
- in_cancel → CHECK with total treated as 0 and no items.
  - Feasible: skip VEND, go to CHANGE.
  - Infeasible: out_err_nochange pulse, credit retained.
- Planner: bounded greedy.
  - n1=min(r/4,c1), then n05=min(r'/2,c05), then n025=min(r'',c025). Feasible iff the residue is 0.
  - This is exact for the divisible 4/2/1 system.
- VEND (1 cycle):
  - out_spit=csel; stock-=csel; csel=0; credit=change.
- CHANGE: one coin per cycle, largest denomination first.
  - Each coin decrements the bank and credit by its value.
  - Leave when credit==0; zero change passes straight through.
- DONE: out_done pulse, then IDLE.
- Latency: in_vend at edge k → CHECK k+1 → out_spit high cycle after edge k+2 → first coin next cycle → out_done one cycle after the last coin.
- While out_busy: all inputs are ignored. Coin pulses are ignored and flagged with out_reject.

Decomposition:
- Package vend_pkg holds:
  - state enum;
  - denomination constants UNIT_5=20, UNIT_1=4, UNIT_05=2, UNIT_025=1;
  - price-slice helper function.
- One combinational sub-module vend_change_planner: inputs amount and bank counts; outputs n1, n05, n025, feasible.

Test Plan:
1. Reset; sel item1; ins_1 ×2; vend → out_spit[1] one cycle, one out_coin_05, then out_done; stock1=3, c05=1, c1=4, credit=0.
2. Reset; sel item0; ins_1 ×2; vend → out_err_nochange, credit=8, csel[0]=1. Then ins_025 and vend → out_spit[0], one out_coin_05, credit=0.
3. Reset; sel item0+item1 (total 13); ins_1 ×2; vend → out_err_funds, no spit, credit=8.
4. Reset; ins_5; sel item3; vend (change 16: 2×$1 + 2×$0.50 leaves 4) → out_err_nochange. Then cancel → out_err_nochange, credit=20.
5. Buy item3 four times with exact $1 → out_stock[3]=0. sel item3 → csel[3] stays 0. restock → out_stock[3]=1.
6. ins_1 ×3; cancel; drop in_restart_n after the first out_coin_1 → no further coin pulses; credit=0, bank=INIT values.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending datapath: FSM states, coin
// denominations in quarter units and the packed price-table slicer.
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_VEND,
      ST_CHANGE,
      ST_DONE
   } vendState_t;

   localparam int UNIT_5   = 20;
   localparam int UNIT_1   = 4;
   localparam int UNIT_05  = 2;
   localparam int UNIT_025 = 1;

   localparam int PRICES_MAX_W  = 1024;
   localparam int PRICE_SLICE_W = 64;

   // Extracts price 'idx' of 'width' bits from a zero-extended packed table.
   function automatic logic [PRICE_SLICE_W-1:0] priceSlice(
      input logic [PRICES_MAX_W-1:0] prices,
      input int unsigned             idx,
      input int unsigned             width
   );
      logic [PRICES_MAX_W-1:0]  shifted;
      logic [PRICE_SLICE_W-1:0] mask;
      shifted = prices >> (idx * width);
      mask = (width >= PRICE_SLICE_W) ? '1
           : ((PRICE_SLICE_W'(1) << width) - PRICE_SLICE_W'(1));
      return PRICE_SLICE_W'(shifted) & mask;
   endfunction

endpackage

// File: rtl/vend_change_planner.sv
// Bounded greedy change planner for the 4/2/1 quarter-unit coin system;
// purely combinational, feasible only when the greedy residue reaches zero.
module vend_change_planner
   import vend_pkg::*;
#(
   parameter int MONEY_W = 16,
   parameter int CNT_W   = 8
)(
   input  logic [MONEY_W-1:0] i_amount,
   input  logic [CNT_W-1:0]   i_c1,
   input  logic [CNT_W-1:0]   i_c05,
   input  logic [CNT_W-1:0]   i_c025,
   output logic [CNT_W-1:0]   o_n1,
   output logic [CNT_W-1:0]   o_n05,
   output logic [CNT_W-1:0]   o_n025,
   output logic               o_feasible
);

   localparam int W = ((MONEY_W > CNT_W) ? MONEY_W : CNT_W) + 1;

   logic [W-1:0] w_amt;
   logic [W-1:0] w_q1;
   logic [W-1:0] w_n1;
   logic [W-1:0] w_r1;
   logic [W-1:0] w_q05;
   logic [W-1:0] w_n05;
   logic [W-1:0] w_r2;
   logic [W-1:0] w_n025;
   logic [W-1:0] w_r3;
   logic [W-1:0] w_c1;
   logic [W-1:0] w_c05;
   logic [W-1:0] w_c025;

   assign w_amt  = W'(i_amount);
   assign w_c1   = W'(i_c1);
   assign w_c05  = W'(i_c05);
   assign w_c025 = W'(i_c025);

   assign w_q1   = w_amt / W'(UNIT_1);
   assign w_n1   = (w_q1 < w_c1) ? w_q1 : w_c1;
   assign w_r1   = w_amt - (w_n1 * W'(UNIT_1));

   assign w_q05  = w_r1 / W'(UNIT_05);
   assign w_n05  = (w_q05 < w_c05) ? w_q05 : w_c05;
   assign w_r2   = w_r1 - (w_n05 * W'(UNIT_05));

   assign w_n025 = (w_r2 < w_c025) ? w_r2 : w_c025;
   assign w_r3   = w_r2 - w_n025;

   assign o_n1       = CNT_W'(w_n1);
   assign o_n05      = CNT_W'(w_n05);
   assign o_n025     = CNT_W'(w_n025);
   assign o_feasible = (w_r3 == '0);

endmodule

// File: rtl/vend_dp_gen.sv
// Parametrised vending-machine datapath: item stocks, change bank, credit
// accumulation, and the IDLE/CHECK/VEND/CHANGE/DONE purchase sequencer.
module vend_dp_gen
   import vend_pkg::*;
#(
   parameter int                         N_ITEMS    = 4,
   parameter int                         MONEY_W    = 16,
   parameter int                         CNT_W      = 8,
   parameter logic [N_ITEMS*MONEY_W-1:0] PRICES     = {16'd4, 16'd5, 16'd6, 16'd7},
   parameter int                         INIT_STOCK = 4,
   parameter int                         INIT_C1    = 2,
   parameter int                         INIT_C05   = 2,
   parameter int                         INIT_C025  = 0
)(
   input  logic               in_clka,
   input  logic               in_restart_n,
   input  logic [N_ITEMS-1:0] in_sel,
   input  logic               in_ins_5,
   input  logic               in_ins_1,
   input  logic               in_ins_05,
   input  logic               in_ins_025,
   input  logic               in_vend,
   input  logic               in_cancel,
   input  logic               in_restock,
   output logic [N_ITEMS-1:0] out_stock,
   output logic [N_ITEMS-1:0] out_csel,
   output logic [MONEY_W-1:0] out_credit,
   output logic [MONEY_W-1:0] out_total,
   output logic [N_ITEMS-1:0] out_spit,
   output logic               out_coin_1,
   output logic               out_coin_05,
   output logic               out_coin_025,
   output logic               out_busy,
   output logic               out_done,
   output logic               out_err_funds,
   output logic               out_err_nochange,
   output logic               out_reject
);

   vendState_t         r_state;
   vendState_t         w_nextState;

   logic [MONEY_W-1:0] r_credit;
   logic [N_ITEMS-1:0] r_csel;
   logic [CNT_W-1:0]   r_stock [N_ITEMS];
   logic [CNT_W-1:0]   r_c1;
   logic [CNT_W-1:0]   r_c05;
   logic [CNT_W-1:0]   r_c025;
   logic [CNT_W-1:0]   r_n1;
   logic [CNT_W-1:0]   r_n05;
   logic [CNT_W-1:0]   r_n025;
   logic               r_isCancel;

   logic [N_ITEMS-1:0] r_spit;
   logic               r_coin1;
   logic               r_coin05;
   logic               r_coin025;
   logic               r_done;
   logic               r_errFunds;
   logic               r_errNochange;
   logic               r_reject;

   logic [MONEY_W-1:0] w_price [N_ITEMS];
   logic [N_ITEMS-1:0] w_stockNz;
   logic [MONEY_W-1:0] w_total;
   logic [MONEY_W-1:0] w_change;
   logic               w_fundsBad;
   logic [CNT_W-1:0]   w_planN1;
   logic [CNT_W-1:0]   w_planN05;
   logic [CNT_W-1:0]   w_planN025;
   logic               w_planOk;
   logic               w_insAny;
   logic [MONEY_W:0]   w_insSum;
   logic [MONEY_W:0]   w_creditSum;
   logic               w_insOverflow;
   logic [MONEY_W-1:0] w_coinVal;
   logic               w_payCoin;

   for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
      assign w_price[i]   = MONEY_W'(priceSlice(PRICES_MAX_W'(PRICES), i, MONEY_W));
      assign w_stockNz[i] = |r_stock[i];
   end

   always_comb begin
      w_total = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (r_csel[i]) begin
            w_total = w_total + w_price[i];
         end
      end
   end

   // A cancel is a purchase of nothing: every credit unit goes back as change.
   assign w_fundsBad = !r_isCancel && ((w_total == '0) || (r_credit < w_total));
   assign w_change   = r_isCancel ? r_credit : (r_credit - w_total);

   vend_change_planner #(
      .MONEY_W (MONEY_W),
      .CNT_W   (CNT_W)
   ) u_planner (
      .i_amount   (w_change),
      .i_c1       (r_c1),
      .i_c05      (r_c05),
      .i_c025     (r_c025),
      .o_n1       (w_planN1),
      .o_n05      (w_planN05),
      .o_n025     (w_planN025),
      .o_feasible (w_planOk)
   );

   assign w_insAny      = in_ins_5 | in_ins_1 | in_ins_05 | in_ins_025;
   assign w_insSum      = (MONEY_W+1)'(in_ins_5   ? UNIT_5   : 0)
                        + (MONEY_W+1)'(in_ins_1   ? UNIT_1   : 0)
                        + (MONEY_W+1)'(in_ins_05  ? UNIT_05  : 0)
                        + (MONEY_W+1)'(in_ins_025 ? UNIT_025 : 0);
   assign w_creditSum   = {1'b0, r_credit} + w_insSum;
   assign w_insOverflow = w_creditSum[MONEY_W];

   assign w_coinVal = (r_n1  != '0) ? MONEY_W'(UNIT_1)
                    : (r_n05 != '0) ? MONEY_W'(UNIT_05)
                    : (r_n025 != '0) ? MONEY_W'(UNIT_025)
                    : '0;
   assign w_payCoin = (r_state == ST_CHANGE) && (r_credit != '0) && (w_coinVal != '0);

   always_ff @(posedge in_clka) begin
      if (!in_restart_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (in_cancel || in_vend) begin
               w_nextState = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_fundsBad || !w_planOk) begin
               w_nextState = ST_IDLE;
            end else if (r_isCancel) begin
               w_nextState = ST_CHANGE;
            end else begin
               w_nextState = ST_VEND;
            end
         end
         ST_VEND: w_nextState = ST_CHANGE;
         // Leave together with the last coin so out_done follows it directly.
         ST_CHANGE: begin
            if (!w_payCoin || (r_credit == w_coinVal)) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clka) begin
      if (!in_restart_n) begin
         r_credit      <= '0;
         r_csel        <= '0;
         for (int i = 0; i < N_ITEMS; i++) begin
            r_stock[i] <= CNT_W'(INIT_STOCK);
         end
         r_c1          <= CNT_W'(INIT_C1);
         r_c05         <= CNT_W'(INIT_C05);
         r_c025        <= CNT_W'(INIT_C025);
         r_n1          <= '0;
         r_n05         <= '0;
         r_n025        <= '0;
         r_isCancel    <= 1'b0;
         r_spit        <= '0;
         r_coin1       <= 1'b0;
         r_coin05      <= 1'b0;
         r_coin025     <= 1'b0;
         r_done        <= 1'b0;
         r_errFunds    <= 1'b0;
         r_errNochange <= 1'b0;
         r_reject      <= 1'b0;
      end else begin
         r_spit        <= '0;
         r_coin1       <= 1'b0;
         r_coin05      <= 1'b0;
         r_coin025     <= 1'b0;
         r_done        <= 1'b0;
         r_errFunds    <= 1'b0;
         r_errNochange <= 1'b0;
         r_reject      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_insAny) begin
                  if (w_insOverflow) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_credit <= w_creditSum[MONEY_W-1:0];
                     r_c1     <= r_c1   + CNT_W'(in_ins_1   && (r_c1   != '1));
                     r_c05    <= r_c05  + CNT_W'(in_ins_05  && (r_c05  != '1));
                     r_c025   <= r_c025 + CNT_W'(in_ins_025 && (r_c025 != '1));
                  end
               end
               if (in_cancel || in_vend) begin
                  r_isCancel <= in_cancel;
               end else begin
                  r_csel <= (r_csel ^ in_sel) & w_stockNz;
                  if (in_restock) begin
                     for (int i = 0; i < N_ITEMS; i++) begin
                        r_stock[i] <= CNT_W'(INIT_STOCK);
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (w_fundsBad) begin
                  r_errFunds <= 1'b1;
               end else if (!w_planOk) begin
                  r_errNochange <= 1'b1;
               end else begin
                  r_n1   <= w_planN1;
                  r_n05  <= w_planN05;
                  r_n025 <= w_planN025;
               end
            end
            ST_VEND: begin
               r_spit <= r_csel;
               for (int i = 0; i < N_ITEMS; i++) begin
                  r_stock[i] <= r_stock[i] - CNT_W'(r_csel[i]);
               end
               r_csel   <= '0;
               r_credit <= w_change;
            end
            ST_CHANGE: begin
               if (w_payCoin) begin
                  r_credit <= r_credit - w_coinVal;
                  if (r_n1 != '0) begin
                     r_n1    <= r_n1 - CNT_W'(1);
                     r_c1    <= r_c1 - CNT_W'(1);
                     r_coin1 <= 1'b1;
                  end else if (r_n05 != '0) begin
                     r_n05    <= r_n05 - CNT_W'(1);
                     r_c05    <= r_c05 - CNT_W'(1);
                     r_coin05 <= 1'b1;
                  end else begin
                     r_n025    <= r_n025 - CNT_W'(1);
                     r_c025    <= r_c025 - CNT_W'(1);
                     r_coin025 <= 1'b1;
                  end
               end
            end
            ST_DONE: r_done <= 1'b1;
            default: ;
         endcase
         if ((r_state != ST_IDLE) && w_insAny) begin
            r_reject <= 1'b1;
         end
      end
   end

   assign out_stock        = w_stockNz;
   assign out_csel         = r_csel;
   assign out_credit       = r_credit;
   assign out_total        = w_total;
   assign out_spit         = r_spit;
   assign out_coin_1       = r_coin1;
   assign out_coin_05      = r_coin05;
   assign out_coin_025     = r_coin025;
   assign out_busy         = (r_state != ST_IDLE);
   assign out_done         = r_done;
   assign out_err_funds    = r_errFunds;
   assign out_err_nochange = r_errNochange;
   assign out_reject       = r_reject;

endmodule

// File: tb/tb_vend_dp_gen.sv
// Directed bench for vend_dp_gen: hand-computed purchases, change, errors,
// rejection, restock and reset during change payout.
module tb_vend_dp_gen;

   logic       in_clka;
   logic       in_restart_n;
   logic [3:0] in_sel;
   logic       in_ins_5;
   logic       in_ins_1;
   logic       in_ins_05;
   logic       in_ins_025;
   logic       in_vend;
   logic       in_cancel;
   logic       in_restock;
   logic [3:0] out_stock;
   logic [3:0] out_csel;
   logic [15:0] out_credit;
   logic [15:0] out_total;
   logic [3:0] out_spit;
   logic       out_coin_1;
   logic       out_coin_05;
   logic       out_coin_025;
   logic       out_busy;
   logic       out_done;
   logic       out_err_funds;
   logic       out_err_nochange;
   logic       out_reject;

   int nCompared;
   int nMismatched;

   int coin1Count;
   int coin05Count;
   int coin025Count;
   int spitCount;
   logic [3:0] spitMask;
   int doneCount;
   int errFundsCount;
   int errNochangeCount;
   int rejectCount;

   vend_dp_gen dut (
      .in_clka          (in_clka),
      .in_restart_n     (in_restart_n),
      .in_sel           (in_sel),
      .in_ins_5         (in_ins_5),
      .in_ins_1         (in_ins_1),
      .in_ins_05        (in_ins_05),
      .in_ins_025       (in_ins_025),
      .in_vend          (in_vend),
      .in_cancel        (in_cancel),
      .in_restock       (in_restock),
      .out_stock        (out_stock),
      .out_csel         (out_csel),
      .out_credit       (out_credit),
      .out_total        (out_total),
      .out_spit         (out_spit),
      .out_coin_1       (out_coin_1),
      .out_coin_05      (out_coin_05),
      .out_coin_025     (out_coin_025),
      .out_busy         (out_busy),
      .out_done         (out_done),
      .out_err_funds    (out_err_funds),
      .out_err_nochange (out_err_nochange),
      .out_reject       (out_reject)
   );

   initial in_clka = 1'b0;
   always #5 in_clka = ~in_clka;

   // Pulse monitor samples shortly after each rising edge, once per cycle.
   always @(posedge in_clka) begin
      #2;
      if (out_coin_1)       coin1Count++;
      if (out_coin_05)      coin05Count++;
      if (out_coin_025)     coin025Count++;
      if (|out_spit)        spitCount++;
      spitMask = spitMask | out_spit;
      if (out_done)         doneCount++;
      if (out_err_funds)    errFundsCount++;
      if (out_err_nochange) errNochangeCount++;
      if (out_reject)       rejectCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic clearCounts();
      coin1Count = 0; coin05Count = 0; coin025Count = 0;
      spitCount = 0; spitMask = '0; doneCount = 0;
      errFundsCount = 0; errNochangeCount = 0; rejectCount = 0;
   endtask

   task automatic applyStimulus(input logic [3:0] sel, input logic i5, input logic i1,
                                input logic i05, input logic i025, input logic vend,
                                input logic cancel, input logic restock);
      in_sel = sel; in_ins_5 = i5; in_ins_1 = i1; in_ins_05 = i05; in_ins_025 = i025;
      in_vend = vend; in_cancel = cancel; in_restock = restock;
      @(negedge in_clka);
      in_sel = '0; in_ins_5 = 0; in_ins_1 = 0; in_ins_05 = 0; in_ins_025 = 0;
      in_vend = 0; in_cancel = 0; in_restock = 0;
   endtask

   task automatic applyReset();
      in_restart_n = 1'b0;
      repeat (2) @(negedge in_clka);
      in_restart_n = 1'b1;
      @(negedge in_clka);
      clearCounts();
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (out_busy && n < 40) begin
         @(negedge in_clka);
         n++;
      end
      checkOutput(tag, 32'(out_busy), 0);
   endtask

   initial begin
      nCompared = 0;
      nMismatched = 0;
      in_restart_n = 1'b1;
      in_sel = '0; in_ins_5 = 0; in_ins_1 = 0; in_ins_05 = 0; in_ins_025 = 0;
      in_vend = 0; in_cancel = 0; in_restock = 0;
      clearCounts();
      @(negedge in_clka);

      // Reset state
      applyReset();
      checkOutput("rstCredit", 32'(out_credit), 0);
      checkOutput("rstCsel", 32'(out_csel), 0);
      checkOutput("rstStock", 32'(out_stock), 4'hF);
      checkOutput("rstBusy", 32'(out_busy), 0);
      checkOutput("rstTotal", 32'(out_total), 0);
      checkOutput("rstC1", 32'(dut.r_c1), 2);

      $display("[TB] test 1: item1 with 50c change");
      applyStimulus(4'b0010, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t1Total", 32'(out_total), 6);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("t1CreditIn", 32'(out_credit), 8);
      applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
      waitIdle("t1Idle");
      checkOutput("t1SpitCount", 32'(spitCount), 1);
      checkOutput("t1SpitMask", 32'(spitMask), 4'b0010);
      checkOutput("t1Coin05", 32'(coin05Count), 1);
      checkOutput("t1Coin1", 32'(coin1Count), 0);
      checkOutput("t1Done", 32'(doneCount), 1);
      checkOutput("t1Credit", 32'(out_credit), 0);
      checkOutput("t1Stock1", 32'(dut.r_stock[1]), 3);
      checkOutput("t1C05", 32'(dut.r_c05), 1);
      checkOutput("t1C1", 32'(dut.r_c1), 4);
      checkOutput("t1Csel", 32'(out_csel), 0);

      $display("[TB] test 2: no exact change then retry");
      applyReset();
      applyStimulus(4'b0001, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
      waitIdle("t2Idle1");
      checkOutput("t2Nochange", 32'(errNochangeCount), 1);
      checkOutput("t2Credit1", 32'(out_credit), 8);
      checkOutput("t2Csel", 32'(out_csel), 4'b0001);
      checkOutput("t2NoSpit", 32'(spitCount), 0);
      applyStimulus(4'b0000, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("t2Credit2", 32'(out_credit), 9);
      applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
      waitIdle("t2Idle2");
      checkOutput("t2SpitMask", 32'(spitMask), 4'b0001);
      checkOutput("t2Coin05", 32'(coin05Count), 1);
      checkOutput("t2Credit3", 32'(out_credit), 0);

      $display("[TB] test 3: insufficient funds");
      applyReset();
      applyStimulus(4'b0011, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3Total", 32'(out_total), 13);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
      waitIdle("t3Idle");
      checkOutput("t3Funds", 32'(errFundsCount), 1);
      checkOutput("t3NoSpit", 32'(spitCount), 0);
      checkOutput("t3Credit", 32'(out_credit), 8);

      $display("[TB] test 4: $5 cannot be changed");
      applyReset();
      applyStimulus(4'b0000, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(4'b1000, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4Credit0", 32'(out_credit), 20);
      checkOutput("t4C1", 32'(dut.r_c1), 2);
      applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
      waitIdle("t4Idle1");
      checkOutput("t4Nochange1", 32'(errNochangeCount), 1);
      applyStimulus(4'b0000, 0, 0, 0, 0, 0, 1, 0);
      waitIdle("t4Idle2");
      checkOutput("t4Nochange2", 32'(errNochangeCount), 2);
      checkOutput("t4Credit", 32'(out_credit), 20);
      checkOutput("t4Done", 32'(doneCount), 0);

      $display("[TB] test 5: empty slot and restock");
      applyReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'b1000, 0, 0, 0, 0, 0, 0, 0);
         applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
         applyStimulus(4'b0000, 0, 0, 0, 0, 1, 0, 0);
         waitIdle("t5Idle");
      end
      checkOutput("t5Done", 32'(doneCount), 4);
      checkOutput("t5Spits", 32'(spitCount), 4);
      checkOutput("t5NoCoins", 32'(coin1Count + coin05Count + coin025Count), 0);
      checkOutput("t5Stock", 32'(out_stock), 4'b0111);
      applyStimulus(4'b1000, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t5CselEmpty", 32'(out_csel), 0);
      applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("t5Restock", 32'(out_stock), 4'hF);

      $display("[TB] test 6: reset during change payout");
      applyReset();
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("t6C1", 32'(dut.r_c1), 5);
      applyStimulus(4'b0000, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(4'b0000, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("t6Reject", 32'(rejectCount), 1);
      checkOutput("t6CreditHeld", 32'(out_credit), 12);
      begin
         int n;
         n = 0;
         while (coin1Count == 0 && n < 20) begin
            @(negedge in_clka);
            n++;
         end
      end
      checkOutput("t6FirstCoin", 32'(coin1Count), 1);
      in_restart_n = 1'b0;
      repeat (2) @(negedge in_clka);
      in_restart_n = 1'b1;
      repeat (5) @(negedge in_clka);
      checkOutput("t6CoinsAfter", 32'(coin1Count), 1);
      checkOutput("t6Credit", 32'(out_credit), 0);
      checkOutput("t6BankC1", 32'(dut.r_c1), 2);
      checkOutput("t6BankC05", 32'(dut.r_c05), 2);
      checkOutput("t6Busy", 32'(out_busy), 0);

      $display("[TB] test 7: vend with nothing selected");
      applyReset();
      applyStimulus(4'b0000, 0, 1, 0, 0, 1, 0, 0);
      waitIdle("t7Idle");
      checkOutput("t7Funds", 32'(errFundsCount), 1);
      checkOutput("t7Credit", 32'(out_credit), 4);

      $display("[TB] test 8: credit overflow rejected");
      applyReset();
      for (int k = 0; k < 3276; k++) begin
         applyStimulus(4'b0000, 1, 0, 0, 0, 0, 0, 0);
      end
      checkOutput("t8CreditHigh", 32'(out_credit), 65520);
      applyStimulus(4'b0000, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("t8Reject", 32'(rejectCount), 1);
      checkOutput("t8CreditKept", 32'(out_credit), 65520);
      checkOutput("t8BankKept", 32'(dut.r_c1), 2);
      applyStimulus(4'b0000, 0, 1, 1, 1, 0, 0, 0);
      checkOutput("t8CreditFill", 32'(out_credit), 65527);
      checkOutput("t8RejectOnce", 32'(rejectCount), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
